muldiv_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit with HI/LO result registers, the sequential companion to the single-cycle ALU in the MIPS datapath. It executes `mult`, `multu`, `div` and `divu` over WIDTH+1 iteration/fix-up cycles, using a shift-add multiplier and a restoring divider. It holds results in HI/LO for `mfhi`/`mflo` and accepts direct HI/LO writes for `mthi`/`mtlo`. A start/busy/done handshake lets the control unit stall on HI/LO reads while an operation runs.

---
 rtl/muldiv_unit.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// Shift-add multiplier and restoring divider on operand magnitudes, sign fix-up in a final cycle.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e               state_q, state_d;
  logic                 div_q, div_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     ma_q, ma_d;
  logic [WIDTH-1:0]     mb_q, mb_d;
  logic                 sgn_pq_q, sgn_pq_d;
  logic                 sgn_r_q, sgn_r_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 dz_q, dz_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 signed_in;
  logic [WIDTH-1:0]     ma_in, mb_in;
  logic [WIDTH:0]       msum;
  logic [WIDTH:0]       rem_sh;
  logic                 rem_ge;
  logic [WIDTH-1:0]     rem_sub;
  logic [2*WIDTH-1:0]   prod_f;
  logic [WIDTH-1:0]     quo_f, rem_f;

  assign signed_in = ~op[0];
  assign ma_in     = (signed_in && a[WIDTH-1]) ? -a : a;
  assign mb_in     = (signed_in && b[WIDTH-1]) ? -b : b;

  // Multiply: prod holds {partial sum, remaining multiplier bits}.
  assign msum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? ma_q : '0)};

  // Divide: prod[WIDTH-1:0] shifts dividend bits out and quotient bits in.
  assign rem_sh  = {rem_q, prod_q[WIDTH-1]};
  assign rem_ge  = rem_sh >= {1'b0, mb_q};
  assign rem_sub = WIDTH'(rem_sh - {1'b0, mb_q});

  assign prod_f = sgn_pq_q ? -prod_q : prod_q;
  assign quo_f  = sgn_pq_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
  assign rem_f  = sgn_r_q ? -rem_q : rem_q;

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    a_d      = a_q;
    b_d      = b_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    sgn_pq_d = sgn_pq_q;
    sgn_r_d  = sgn_r_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          div_d    = op[1];
          a_d      = a;
          b_d      = b;
          ma_d     = ma_in;
          mb_d     = mb_in;
          sgn_pq_d = signed_in & (a[WIDTH-1] ^ b[WIDTH-1]);
          sgn_r_d  = signed_in & a[WIDTH-1];
          cnt_d    = '0;
          dz_d     = 1'b0;
          prod_d   = {{WIDTH{1'b0}}, (op[1] ? ma_in : mb_in)};
          rem_d    = '0;
          busy_d   = 1'b1;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        if (div_q) begin
          rem_d              = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
          prod_d[WIDTH-1:0]  = {prod_q[WIDTH-2:0], rem_ge};
        end else begin
          prod_d = {msum, prod_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = StFix;
      end
      StFix: begin
        if (div_q) begin
          if (b_q == '0) begin
            dz_d = 1'b1;
            lo_d = '1;
            hi_d = a_q;
          end else begin
            lo_d = quo_f;
            hi_d = rem_f;
          end
        end else begin
          {hi_d, lo_d} = prod_f;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      div_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      ma_q     <= '0;
      mb_q     <= '0;
      sgn_pq_q <= 1'b0;
      sgn_r_q  <= 1'b0;
      cnt_q    <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      sgn_pq_q <= sgn_pq_d;
      sgn_r_q  <= sgn_r_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dz   = dz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: 32-bit and 8-bit instances checked against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel8;
  logic        start_s, hi_we_s, lo_we_s;
  logic [1:0]  op_s;
  logic [31:0] a_s, b_s, wdata_s;

  logic        busy32, done32, dz32;
  logic [31:0] hi32, lo32;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  logic        busy_o, done_o, dz_o;
  logic [31:0] hi_o, lo_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) u_dut32 (
    .clk   (clk),
    .rst   (rst),
    .start (start_s & ~sel8),
    .op    (op_s),
    .a     (a_s),
    .b     (b_s),
    .hi_we (hi_we_s & ~sel8),
    .lo_we (lo_we_s & ~sel8),
    .wdata (wdata_s),
    .busy  (busy32),
    .done  (done32),
    .dz    (dz32),
    .hi    (hi32),
    .lo    (lo32)
  );

  muldiv_unit #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start_s & sel8),
    .op    (op_s),
    .a     (a_s[7:0]),
    .b     (b_s[7:0]),
    .hi_we (hi_we_s & sel8),
    .lo_we (lo_we_s & sel8),
    .wdata (wdata_s[7:0]),
    .busy  (busy8),
    .done  (done8),
    .dz    (dz8),
    .hi    (hi8),
    .lo    (lo8)
  );

  always_comb begin
    busy_o = sel8 ? busy8 : busy32;
    done_o = sel8 ? done8 : done32;
    dz_o   = sel8 ? dz8 : dz32;
    hi_o   = sel8 ? {24'b0, hi8} : hi32;
    lo_o   = sel8 ? {24'b0, lo8} : lo32;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: MIPS semantics straight from integer arithmetic on w-bit operands.
  function automatic void ref_model(input int w, input logic [1:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output logic [63:0] ehi,
                                    output logic [63:0] elo, output logic edz);
    logic [63:0] mask, ua, ub, up;
    longint      sa, sb, sp;
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'b0, a} & mask;
    ub   = {32'b0, b} & mask;
    sa   = longint'(ua << (64 - w)) >>> (64 - w);
    sb   = longint'(ub << (64 - w)) >>> (64 - w);
    edz  = 1'b0;
    case (op)
      2'd0: begin
        sp  = sa * sb;
        elo = 64'(sp) & mask;
        ehi = 64'(sp >>> w) & mask;
      end
      2'd1: begin
        up  = ua * ub;
        elo = up & mask;
        ehi = (up >> w) & mask;
      end
      2'd2: begin
        if (sb == 0) begin
          edz = 1'b1; elo = mask; ehi = ua;
        end else begin
          elo = 64'(sa / sb) & mask;
          ehi = 64'(sa % sb) & mask;
        end
      end
      default: begin
        if (ub == 0) begin
          edz = 1'b1; elo = mask; ehi = ua;
        end else begin
          elo = ua / ub;
          ehi = ua % ub;
        end
      end
    endcase
  endfunction

  // Issue one op and wait for done; with noise, random start/mthi/mtlo hit the busy window.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit noise);
    int          w, n, nbusy;
    logic [63:0] ehi, elo;
    logic        edz;
    w = sel8 ? 8 : 32;
    ref_model(w, op, a, b, ehi, elo, edz);
    @(negedge clk);
    start_s = 1'b1; op_s = op; a_s = a; b_s = b; hi_we_s = 1'b0; lo_we_s = 1'b0;
    @(posedge clk); #1;
    start_s = 1'b0;
    chk($sformatf("busy_after_accept w%0d op%0d", w, op), 64'(busy_o), 64'd1);
    chk($sformatf("done_low_after_accept w%0d op%0d", w, op), 64'(done_o), 64'd0);
    n = 0;
    nbusy = busy_o ? 1 : 0;
    while (!done_o && n < 200) begin
      if (noise) begin
        start_s = 1'($urandom); hi_we_s = 1'($urandom); lo_we_s = 1'($urandom);
        op_s = 2'($urandom); a_s = $urandom; b_s = $urandom; wdata_s = $urandom;
      end
      @(posedge clk); #1;
      n++;
      if (busy_o) nbusy++;
      if (done_o) begin
        start_s = 1'b0; hi_we_s = 1'b0; lo_we_s = 1'b0;
      end
    end
    start_s = 1'b0; hi_we_s = 1'b0; lo_we_s = 1'b0;
    chk($sformatf("latency w%0d op%0d", w, op), 64'(n), 64'(w + 1));
    chk($sformatf("busy_cycles w%0d op%0d", w, op), 64'(nbusy), 64'(w + 1));
    chk($sformatf("busy_at_done w%0d op%0d", w, op), 64'(busy_o), 64'd0);
    chk($sformatf("hi w%0d op%0d a=%0h b=%0h", w, op, a, b), 64'(hi_o), ehi);
    chk($sformatf("lo w%0d op%0d a=%0h b=%0h", w, op, a, b), 64'(lo_o), elo);
    chk($sformatf("dz w%0d op%0d a=%0h b=%0h", w, op, a, b), 64'(dz_o), 64'(edz));
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b;
    logic        done_seen;

    rst = 1'b1; sel8 = 1'b0;
    start_s = 1'b0; hi_we_s = 1'b0; lo_we_s = 1'b0;
    op_s = 2'd0; a_s = '0; b_s = '0; wdata_s = '0;
    #1;
    chk("reset hi32", 64'(hi32), 64'd0);
    chk("reset lo32", 64'(lo32), 64'd0);
    chk("reset busy32", 64'(busy32), 64'd0);
    chk("reset done32", 64'(done32), 64'd0);
    chk("reset dz32", 64'(dz32), 64'd0);
    chk("reset hi8", 64'(hi8), 64'd0);
    chk("reset busy8", 64'(busy8), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed vectors, issued back-to-back.
    run_op(2'd0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    chk("mult -1*2 hi const", 64'(hi_o), 64'hFFFF_FFFF);
    run_op(2'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    chk("multu hi const", 64'(hi_o), 64'h0000_0001);
    run_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    run_op(2'd3, 32'h0000_0007, 32'h0000_0000, 1'b0);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'd2, 32'h0000_0005, 32'h0000_0000, 1'b0);
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);

    // mthi / mtlo while idle.
    @(negedge clk); hi_we_s = 1'b1; wdata_s = 32'hCAFE_F00D;
    @(negedge clk); hi_we_s = 1'b0; lo_we_s = 1'b1; wdata_s = 32'h1357_9BDF;
    @(negedge clk); lo_we_s = 1'b0;
    chk("mthi", 64'(hi_o), 64'hCAFE_F00D);
    chk("mtlo", 64'(lo_o), 64'h1357_9BDF);

    // Start/hi_we/lo_we while busy must be ignored.
    run_op(2'd0, 32'h0000_1234, 32'h0000_5678, 1'b1);

    // Reset mid-operation aborts without a done.
    @(negedge clk); start_s = 1'b1; op_s = 2'd1; a_s = 32'hDEAD_BEEF; b_s = 32'h0000_0003;
    @(posedge clk); #1; start_s = 1'b0;
    repeat (19) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort hi", 64'(hi_o), 64'd0);
    chk("abort lo", 64'(lo_o), 64'd0);
    chk("abort busy", 64'(busy_o), 64'd0);
    chk("abort dz", 64'(dz_o), 64'd0);
    @(negedge clk); rst = 1'b0;
    done_seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done_o) done_seen = 1'b1;
    end
    chk("no done after abort", 64'(done_seen), 64'd0);
    run_op(2'd1, 32'hDEAD_BEEF, 32'h0000_0003, 1'b0);

    for (int i = 0; i < 24; i++) begin
      r_op = 2'($urandom); r_a = $urandom; r_b = $urandom;
      case ($urandom_range(7))
        0: r_b = 32'd0;
        1: r_b = 32'($urandom_range(15));
        2: r_a = 32'h8000_0000;
        3: r_b = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(r_op, r_a, r_b, (i % 3) == 0);
    end

    // 8-bit instance.
    @(negedge clk); sel8 = 1'b1;
    run_op(2'd0, 32'h7F, 32'h7F, 1'b0);
    chk("w8 0x7F*0x7F hi const", 64'(hi_o), 64'h3F);
    chk("w8 0x7F*0x7F lo const", 64'(lo_o), 64'h01);
    run_op(2'd2, 32'h80, 32'hFF, 1'b0);
    run_op(2'd3, 32'hA5, 32'h00, 1'b0);
    for (int i = 0; i < 16; i++) begin
      r_op = 2'($urandom); r_a = 32'($urandom_range(255)); r_b = 32'($urandom_range(255));
      if ($urandom_range(5) == 0) r_b = 32'd0;
      run_op(r_op, r_a, r_b, (i % 2) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
